// File: rtl/vga_pixel_fetch_if.sv
// Frame-memory read port between vga_pixel_fetch and the memory arbiter.
//   mem_req  : read request, held until the ack cycle
//   mem_addr : word address, stable while mem_req is high
//   mem_ack  : one-cycle completion strobe
//   mem_data : read data, valid only in the mem_ack cycle
//              ([7:0] even pixel, [15:8] odd pixel)
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 18
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel source stage behind the vga_800x600 timing generator.
// Prefetches packed RGB332 pixel pairs from frame memory into a small FIFO
// and emits one pixel per clock during active video. Holds the timing
// generator frozen until the FIFO is primed, and restarts the frame on each
// vs rising edge.
// Ports:
//   clk, reset         : pixel clock, asynchronous active-high reset
//   hs, vs, blank      : strobes from the timing generator
//   hold               : freezes the timing generator until primed
//   mem                : frame-memory read port (master side)
//   red, green, blue   : registered pixel colour (3/3/2 bits)
//   hs_out, vs_out     : hs/vs delayed to line up with the colour outputs
//   underflow          : sticky flag, an active pixel found the FIFO empty
module vga_pixel_fetch #(
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 240000,
  parameter int ADDR_W      = 18,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 blank,
  output logic                 hold,
  vga_pixel_fetch_if.master    mem,
  output logic [2:0]           red,
  output logic [2:0]           green,
  output logic [1:0]           blue,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

  state_t            state;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              phase;
  logic              vs_p0;

  logic              ack_ok;
  logic              vs_rise;
  logic              restart;
  logic              push;
  logic              active;
  logic              empty;
  logic              pop;
  logic              flush_done;
  logic [15:0]       head;
  logic [7:0]        pix_byte;
  logic [ADDR_W-1:0] next_addr;

  // An ack only counts against a live request; a late ack after reset is dropped.
  assign ack_ok     = mem.mem_req & mem.mem_ack;
  assign vs_rise    = vs & ~vs_p0;
  assign restart    = (state == RUN) & vs_rise;
  // Data returning in FLUSH, or in the cycle that starts a flush, belongs to
  // the old frame and is thrown away.
  assign push       = ack_ok & (state != FLUSH) & ~restart;
  assign active     = (state == RUN) & ~blank;
  assign empty      = (count == '0);
  assign pop        = active & phase & ~empty;
  assign flush_done = (state == FLUSH) & (~mem.mem_req | mem.mem_ack);
  assign head       = fifo_mem[rd_ptr];
  assign pix_byte   = phase ? head[15:8] : head[7:0];
  assign next_addr  = (mem.mem_addr == LAST) ? BASE : mem.mem_addr + ADDR_W'(1);

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem.mem_data;
  end

  // Stage p0 -> outputs: control, fetch and pixel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PRIME;
      hold         <= 1'b1;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= BASE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      phase        <= 1'b0;
      vs_p0        <= 1'b0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      hs_out       <= 1'b0;
      vs_out       <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      vs_p0  <= vs;
      hs_out <= hs;
      vs_out <= vs;

      if (active && !empty) begin
        {red, green, blue} <= pix_byte;
      end else begin
        {red, green, blue} <= 8'd0;
      end

      if (active) begin
        phase <= ~phase;
        if (empty) underflow <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      // Single outstanding request, so "count + outstanding" is just count
      // whenever a new request may start.
      if (ack_ok) begin
        mem.mem_req  <= 1'b0;
        mem.mem_addr <= next_addr;
      end else if (!mem.mem_req && state != FLUSH && !restart && count < FULL) begin
        mem.mem_req <= 1'b1;
      end

      unique case (state)
        PRIME: begin
          if (count == FULL) begin
            state <= RUN;
            hold  <= 1'b0;
          end
        end
        RUN: begin
          if (vs_rise) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_done) begin
            state        <= RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            phase        <= 1'b0;
            mem.mem_addr <= BASE;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
module tb_vga_pixel_fetch;

  logic clk;
  logic reset;
  logic hs, vs, blank;
  logic stall;

  logic       hold, hs_out, vs_out, underflow;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [7:0] pix;

  logic       hold2, hs_out2, vs_out2, underflow2;
  logic [2:0] red2, green2;
  logic [1:0] blue2;

  vga_pixel_fetch_if #(.ADDR_W(18)) bus  ();
  vga_pixel_fetch_if #(.ADDR_W(18)) bus2 ();

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .blank(blank),
    .hold(hold), .mem(bus),
    .red(red), .green(green), .blue(blue),
    .hs_out(hs_out), .vs_out(vs_out), .underflow(underflow)
  );

  // Short frame so the address wrap shows up quickly.
  vga_pixel_fetch #(.FRAME_WORDS(20)) dut_wrap (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .blank(blank),
    .hold(hold2), .mem(bus2),
    .red(red2), .green(green2), .blue(blue2),
    .hs_out(hs_out2), .vs_out(vs_out2), .underflow(underflow2)
  );

  assign pix = {red, green, blue};

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  logic [17:0] addr_log [$];
  logic [17:0] addr_log2 [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: zero-wait ack (one clock after mem_req) unless stalled.
  // Address 0 holds 16'h1234, every other word holds its own address.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req && !stall && !reset) begin
        bus.mem_data = (bus.mem_addr == 18'd0) ? 16'h1234 : bus.mem_addr[15:0];
        bus.mem_ack  = 1'b1;
        addr_log.push_back(bus.mem_addr);
        ack_cnt++;
      end
    end
  end

  initial begin
    bus2.mem_ack  = 1'b0;
    bus2.mem_data = 16'h0;
    forever begin
      @(negedge clk);
      if (bus2.mem_ack) begin
        bus2.mem_ack = 1'b0;
      end else if (bus2.mem_req && !reset) begin
        bus2.mem_data = bus2.mem_addr[15:0];
        bus2.mem_ack  = 1'b1;
        addr_log2.push_back(bus2.mem_addr);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic seen16;
    logic hold_at16;
    reset = 1'b1; hs = 1'b0; vs = 1'b0; blank = 1'b1; stall = 1'b0;
    repeat (3) step();
    check("rst_hold",  32'(hold), 32'd1);
    check("rst_req",   32'(bus.mem_req), 32'd0);
    check("rst_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_pix",   32'(pix), 32'd0);
    check("rst_hsvs",  32'({hs_out, vs_out}), 32'd0);
    check("rst_uf",    32'(underflow), 32'd0);

    // Prime
    reset = 1'b0;
    seen16 = 1'b0;
    hold_at16 = 1'b0;
    for (int i = 0; i < 300 && hold; i++) begin
      step();
      if (ack_cnt == 16 && !seen16) begin
        seen16 = 1'b1;
        hold_at16 = hold;
      end
    end
    check("prime_hold_at_16", 32'(hold_at16), 32'd1);
    check("prime_hold_drop",  32'(hold), 32'd0);
    check("prime_words",      32'(ack_cnt), 32'd16);
    check("prime_addr0",      32'(addr_log[0]), 32'd0);
    check("prime_addr1",      32'(addr_log[1]), 32'd1);
    check("prime_addr2",      32'(addr_log[2]), 32'd2);
    repeat (3) step();
    check("hold_stays", 32'(hold), 32'd0);

    // Pixel order: word 0 = 1234, word 1 = 0001
    blank = 1'b0;
    check("pix_lag", 32'(pix), 32'd0);
    step(); check("pix_w0_lo", 32'(pix), 32'h34);
    step(); check("pix_w0_hi", 32'(pix), 32'h12);
    step(); check("pix_w1_lo", 32'(pix), 32'h01);
    step(); check("pix_w1_hi", 32'(pix), 32'h00);
    blank = 1'b1;
    step(); check("pix_blank", 32'(pix), 32'd0);

    hs = 1'b1;
    check("hs_lag0", 32'(hs_out), 32'd0);
    step(); check("hs_lag1", 32'(hs_out), 32'd1);
    hs = 1'b0;
    step(); check("hs_fall", 32'(hs_out), 32'd0);

    // Frame restart after 1000 fetches
    blank = 1'b0;
    for (int i = 0; i < 4000 && ack_cnt < 1000; i++) step();
    check("run_fetches", 32'(ack_cnt >= 1000), 32'd1);
    check("run_no_uf",   32'(underflow), 32'd0);
    check("wrap_len",    32'(addr_log2.size() >= 22), 32'd1);
    check("wrap_a18",    32'(addr_log2[18]), 32'd18);
    check("wrap_a19",    32'(addr_log2[19]), 32'd19);
    check("wrap_a20",    32'(addr_log2[20]), 32'd0);
    check("wrap_a21",    32'(addr_log2[21]), 32'd1);
    blank = 1'b1;
    vs = 1'b1;
    addr_log.delete();
    step(); check("vs_out", 32'(vs_out), 32'd1);
    repeat (50) step();
    check("restart_len",   32'(addr_log.size() >= 2), 32'd1);
    check("restart_addr0", 32'(addr_log[0]), 32'd0);
    check("restart_addr1", 32'(addr_log[1]), 32'd1);
    vs = 1'b0;
    blank = 1'b0;
    step(); check("restart_pix_lo", 32'(pix), 32'h34);
    step(); check("restart_pix_hi", 32'(pix), 32'h12);

    // Flush with a request outstanding, ack 3 cycles later
    stall = 1'b1;
    for (int i = 0; i < 20 && !(bus.mem_req && !bus.mem_ack); i++) step();
    check("flush_req_up", 32'(bus.mem_req), 32'd1);
    vs = 1'b1;
    blank = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    for (int i = 0; i < 10 && !bus.mem_ack; i++) step();
    check("flush_late_ack", 32'(bus.mem_ack), 32'd1);
    addr_log.delete();
    repeat (50) step();
    check("flush_next_addr", 32'(addr_log[0]), 32'd0);
    vs = 1'b0;
    blank = 1'b0;
    step(); check("flush_pix_lo", 32'(pix), 32'h34);
    step(); check("flush_pix_hi", 32'(pix), 32'h12);

    // Underflow: 64-clock memory stall during active video
    check("uf_before", 32'(underflow), 32'd0);
    stall = 1'b1;
    repeat (64) step();
    check("uf_pix_zero", 32'(pix), 32'd0);
    check("uf_set",      32'(underflow), 32'd1);
    stall = 1'b0;
    repeat (40) step();
    check("uf_sticky",   32'(underflow), 32'd1);
    blank = 1'b1;

    // Asynchronous reset mid-operation
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_hold", 32'(hold), 32'd1);
    check("mid_rst_req",  32'(bus.mem_req), 32'd0);
    check("mid_rst_uf",   32'(underflow), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
